// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_responder_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam logic [WORD_W-1:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch and loader signal bundle between the core/loader (master) and the responder (slave).
interface imem_responder_if;
  import imem_responder_pkg::*;

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [WORD_W-1:0] instruction;
  logic              fetch_misalign;
  logic              load_en;
  logic              load_byte_valid;
  logic [BYTE_W-1:0] load_byte;
  logic              load_done;
  logic              busy;

  modport master (
    output fetch_req, fetch_addr, load_en, load_byte_valid, load_byte,
    input  fetch_valid, instruction, fetch_misalign, load_done, busy
  );

  modport slave (
    input  fetch_req, fetch_addr, load_en, load_byte_valid, load_byte,
    output fetch_valid, instruction, fetch_misalign, load_done, busy
  );

endinterface

// File: rtl/imem_responder_byte_packer.sv
// Assembles little-endian program bytes into 32-bit words; unfilled upper lanes stay zero.
module imem_responder_byte_packer
  import imem_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_c,
  output logic              word_we_c,
  output logic              partial_c
);

  localparam int unsigned CNT_W = 2;

  logic [CNT_W-1:0]  byte_cnt;
  logic [WORD_W-1:0] lanes;
  logic [4:0]        lane_lsb;

  assign lane_lsb  = {byte_cnt, 3'b000};
  assign word_we_c = byte_valid && (byte_cnt == CNT_W'(3));
  assign partial_c = (byte_cnt != '0);

  // Current byte merged into its lane so the 4th byte can be written on the same edge.
  always_comb begin
    word_c = lanes;
    if (byte_valid) word_c[lane_lsb +: BYTE_W] = byte_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      lanes    <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      lanes    <= '0;
    end else if (byte_valid) begin
      if (word_we_c) begin
        byte_cnt <= '0;
        lanes    <= '0;
      end else begin
        byte_cnt <= byte_cnt + CNT_W'(1);
        lanes    <= word_c;
      end
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory answering PC fetches with 1-cycle latency, plus a byte-serial program loader.
module imem_responder #(
  parameter int unsigned DEPTH = 64,
  parameter logic [imem_responder_pkg::WORD_W-1:0] NOP_INSN = imem_responder_pkg::NOP_INSN
) (
  input logic              clk,
  input logic              rst_n,
  imem_responder_if.slave  imem
);
  import imem_responder_pkg::state_t;
  import imem_responder_pkg::S_FETCH;
  import imem_responder_pkg::S_LOAD;
  import imem_responder_pkg::S_FLUSH;
  import imem_responder_pkg::WORD_W;
  import imem_responder_pkg::ADDR_W;

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SPAN_W = ADDR_W + 1;
  localparam logic [SPAN_W-1:0] SPAN = SPAN_W'(DEPTH * 4);

  state_t            state;
  logic [PTR_W-1:0]  word_ptr;
  logic [WORD_W-1:0] mem [DEPTH];

  logic              accept_c;
  logic              clear_c;
  logic              mem_we_c;
  logic              fetch_ok_c;
  logic [PTR_W-1:0]  fetch_idx_c;
  logic [WORD_W-1:0] word_c;
  logic              word_we_c;
  logic              partial_c;

  assign accept_c    = imem.load_byte_valid && (state == S_LOAD);
  assign clear_c     = ((state == S_FETCH) && imem.load_en) || (state == S_FLUSH);
  assign mem_we_c    = word_we_c || ((state == S_FLUSH) && partial_c);
  assign fetch_ok_c  = (imem.fetch_addr[1:0] == 2'b00) && ({1'b0, imem.fetch_addr} < SPAN);
  assign fetch_idx_c = imem.fetch_addr[PTR_W+1:2];

  imem_responder_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear_c),
    .byte_valid (accept_c),
    .byte_in    (imem.load_byte),
    .word_c     (word_c),
    .word_we_c  (word_we_c),
    .partial_c  (partial_c)
  );

  // Program storage is deliberately not reset so a reset mid-load keeps earlier words.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[word_ptr] <= word_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= S_FETCH;
      word_ptr            <= '0;
      imem.fetch_valid    <= 1'b0;
      imem.instruction    <= NOP_INSN;
      imem.fetch_misalign <= 1'b0;
      imem.load_done      <= 1'b0;
      imem.busy           <= 1'b0;
    end else begin
      imem.fetch_valid    <= 1'b0;
      imem.fetch_misalign <= 1'b0;
      imem.load_done      <= 1'b0;
      case (state)
        S_FETCH: begin
          if (imem.load_en) begin
            // Load wins over a same-cycle fetch; the fetch is dropped.
            state     <= S_LOAD;
            word_ptr  <= '0;
            imem.busy <= 1'b1;
          end else if (imem.fetch_req) begin
            imem.fetch_valid <= 1'b1;
            if (fetch_ok_c) begin
              imem.instruction <= mem[fetch_idx_c];
            end else begin
              imem.instruction    <= NOP_INSN;
              imem.fetch_misalign <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (word_we_c) begin
            word_ptr <= (word_ptr == PTR_W'(DEPTH - 1)) ? '0 : word_ptr + PTR_W'(1);
          end
          if (!imem.load_en) begin
            if (partial_c) begin
              state <= S_FLUSH;
            end else begin
              state          <= S_FETCH;
              imem.load_done <= 1'b1;
              imem.busy      <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          state          <= S_FETCH;
          imem.load_done <= 1'b1;
          imem.busy      <= 1'b0;
        end
        default: begin
          state     <= S_FETCH;
          imem.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder at DEPTH 64, 16 and 4, driven with shared stimulus.
module tb_imem_responder;

  localparam int NI = 3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        known;
    logic        mis;
    logic [31:0] insn;
  } exp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] insn;
    logic        mis;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        load_en;
  logic        load_byte_valid;
  logic [7:0]  load_byte;

  logic [NI-1:0] fv, mis, done, busy;
  logic [31:0]   insn [NI];

  int          checks = 0;
  int          failures = 0;
  int          done_cnt [NI];
  int          d0 [NI];
  logic [31:0] last_exp [NI];
  exp_t        sb [NI][$];
  exp_t        mon_e;

  logic [31:0] mm [NI][64];
  logic        mk [NI][64];
  int          m_cnt [NI];
  int          m_ptr [NI];
  logic [31:0] m_lane [NI];
  logic [7:0]  lbuf [32];
  vec_t        tab [6];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned D = (g == 0) ? 64 : (g == 1) ? 16 : 4;
    imem_responder_if bus ();
    assign bus.fetch_req       = fetch_req;
    assign bus.fetch_addr      = fetch_addr;
    assign bus.load_en         = load_en;
    assign bus.load_byte_valid = load_byte_valid;
    assign bus.load_byte       = load_byte;
    assign fv[g]   = bus.fetch_valid;
    assign mis[g]  = bus.fetch_misalign;
    assign done[g] = bus.load_done;
    assign busy[g] = bus.busy;
    assign insn[g] = bus.instruction;
    imem_responder #(.DEPTH(D), .NOP_INSN(32'h0000_0013)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .imem  (bus.slave)
    );
  end

  function automatic int depth_of(input int i);
    return (i == 0) ? 64 : (i == 1) ? 16 : 4;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%h required=%h", nm, inst, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic model_start();
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = 0; m_ptr[i] = 0; m_lane[i] = '0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    for (int i = 0; i < NI; i++) begin
      m_lane[i][m_cnt[i]*8 +: 8] = b;
      m_cnt[i]++;
      if (m_cnt[i] == 4) begin
        mm[i][m_ptr[i]] = m_lane[i];
        mk[i][m_ptr[i]] = 1'b1;
        m_ptr[i] = (m_ptr[i] + 1) % depth_of(i);
        m_cnt[i] = 0;
        m_lane[i] = '0;
      end
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < NI; i++) begin
      if (m_cnt[i] != 0) begin
        mm[i][m_ptr[i]] = m_lane[i];
        mk[i][m_ptr[i]] = 1'b1;
      end
      m_cnt[i] = 0;
      m_lane[i] = '0;
    end
  endtask

  // Drive a fetch and queue the expected response; instance ov takes a fixed expectation.
  task automatic fetch_push(input logic [7:0] a, input int ov, input logic [31:0] ov_insn, input logic ov_mis);
    exp_t e;
    fetch_req  = 1'b1;
    fetch_addr = a;
    for (int i = 0; i < NI; i++) begin
      if (i == ov) begin
        e = '{known: 1'b1, mis: ov_mis, insn: ov_insn};
      end else if (a[1:0] == 2'b00 && int'(a) < depth_of(i) * 4) begin
        e = '{known: mk[i][int'(a[7:2])], mis: 1'b0, insn: mm[i][int'(a[7:2])]};
      end else begin
        e = '{known: 1'b1, mis: 1'b1, insn: NOP};
      end
      sb[i].push_back(e);
    end
  endtask

  task automatic drain();
    fetch_req = 1'b0;
    tick();
    at_neg();
    for (int i = 0; i < NI; i++) chk("sb_drained", i, sb[i].size(), 0);
  endtask

  task automatic snap();
    for (int i = 0; i < NI; i++) d0[i] = done_cnt[i];
  endtask

  task automatic chk_done_delta(input string nm, input int want);
    for (int i = 0; i < NI; i++) chk(nm, i, done_cnt[i] - d0[i], want);
  endtask

  task automatic load_n(input int n);
    load_en = 1'b1;
    tick();
    model_start();
    for (int i = 0; i < NI; i++) chk("load_busy", i, busy[i], 1);
    for (int k = 0; k < n; k++) begin
      load_byte_valid = 1'b1;
      load_byte = lbuf[k];
      model_byte(lbuf[k]);
      tick();
    end
    load_byte_valid = 1'b0;
    load_en = 1'b0;
    tick();
    if (n % 4 != 0) begin
      for (int i = 0; i < NI; i++) begin
        chk("flush_busy", i, busy[i], 1);
        chk("flush_done_early", i, done[i], 0);
      end
      model_flush();
      tick();
    end
    for (int i = 0; i < NI; i++) begin
      chk("end_busy", i, busy[i], 0);
      chk("end_done", i, done[i], 1);
    end
    tick();
  endtask

  // Pops one expectation per valid response and checks it.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        if (done[i]) done_cnt[i]++;
        if (fv[i]) begin
          if (sb[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid inst=%0d actual=1 required=0", i);
          end else begin
            mon_e = sb[i].pop_front();
            chk("resp_misalign", i, mis[i], mon_e.mis);
            if (mon_e.known) begin
              chk("resp_insn", i, insn[i], mon_e.insn);
              last_exp[i] = mon_e.insn;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tab[0] = '{8'h00, 32'h0010_0513, 1'b0};
    tab[1] = '{8'h04, 32'h00B5_05B3, 1'b0};
    tab[2] = '{8'h02, NOP, 1'b1};
    tab[3] = '{8'h01, NOP, 1'b1};
    tab[4] = '{8'h03, NOP, 1'b1};
    tab[5] = '{8'h06, NOP, 1'b1};
    for (int i = 0; i < NI; i++) begin
      done_cnt[i] = 0;
      last_exp[i] = NOP;
      for (int j = 0; j < 64; j++) mk[i][j] = 1'b0;
    end
    model_start();
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = 8'h00;
    load_en = 1'b0; load_byte_valid = 1'b0; load_byte = 8'h00;

    // Reset state with a fetch pulse that must be ignored.
    tick();
    fetch_req = 1'b1;
    tick();
    at_neg();
    for (int i = 0; i < NI; i++) begin
      chk("rst_fetch_valid", i, fv[i], 0);
      chk("rst_instruction", i, insn[i], NOP);
      chk("rst_misalign", i, mis[i], 0);
      chk("rst_busy", i, busy[i], 0);
      chk("rst_load_done", i, done[i], 0);
    end
    fetch_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Two-word program.
    lbuf[0] = 8'h13; lbuf[1] = 8'h05; lbuf[2] = 8'h10; lbuf[3] = 8'h00;
    lbuf[4] = 8'hB3; lbuf[5] = 8'h05; lbuf[6] = 8'hB5; lbuf[7] = 8'h00;
    snap();
    load_n(8);
    chk_done_delta("load8_done_pulses", 1);
    for (int k = 0; k < 6; k++) begin
      fetch_push(tab[k].addr, 0, tab[k].insn, tab[k].mis);
      tick();
    end
    drain();

    // Range boundaries per depth.
    fetch_push(8'h40, 1, NOP, 1'b1);
    tick();
    fetch_push(8'h10, 2, NOP, 1'b1);
    tick();
    fetch_push(8'hFC, -1, NOP, 1'b0);
    tick();
    drain();

    // Partial load with zero padding.
    lbuf[4] = 8'hAA; lbuf[5] = 8'hBB;
    snap();
    load_n(6);
    chk_done_delta("load6_done_pulses", 1);
    fetch_push(8'h04, 0, 32'h0000_BBAA, 1'b0);
    tick();
    fetch_push(8'h00, -1, NOP, 1'b0);
    tick();
    drain();

    // 20 bytes: DEPTH 4 wraps and word 0 ends up with bytes 17-20.
    for (int k = 0; k < 20; k++) lbuf[k] = 8'(k + 1);
    snap();
    load_n(20);
    chk_done_delta("load20_done_pulses", 1);
    fetch_push(8'h00, 2, 32'h1413_1211, 1'b0);
    tick();
    drain();

    // Back-to-back fetches, then PC hold.
    fetch_push(8'h00, 0, 32'h0403_0201, 1'b0);
    tick();
    fetch_push(8'h04, 0, 32'h0807_0605, 1'b0);
    tick();
    fetch_push(8'h08, 0, 32'h0C0B_0A09, 1'b0);
    tick();
    fetch_req = 1'b0;
    at_neg();
    for (int i = 0; i < NI; i++) chk("stream_all_answered", i, sb[i].size(), 0);
    for (int c = 0; c < 5; c++) begin
      at_neg();
      for (int i = 0; i < NI; i++) begin
        chk("hold_fetch_valid", i, fv[i], 0);
        chk("hold_instruction", i, insn[i], last_exp[i]);
      end
    end

    // Reset in the middle of a word.
    snap();
    load_en = 1'b1;
    tick();
    model_start();
    load_byte_valid = 1'b1; load_byte = 8'h5A;
    tick();
    load_byte = 8'hA5;
    tick();
    rst_n = 1'b0;
    #1;
    load_en = 1'b0; load_byte_valid = 1'b0;
    model_start();
    for (int i = 0; i < NI; i++) begin
      chk("midrst_busy", i, busy[i], 0);
      chk("midrst_load_done", i, done[i], 0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk_done_delta("midrst_no_done", 0);
    fetch_push(8'h00, 2, 32'h1413_1211, 1'b0);
    tick();
    fetch_push(8'h04, -1, NOP, 1'b0);
    tick();
    fetch_push(8'h08, -1, NOP, 1'b0);
    tick();
    drain();

    // Fetch just before load_en rises completes; fetch with load_en rising is dropped.
    snap();
    fetch_push(8'h04, -1, NOP, 1'b0);
    tick();
    fetch_addr = 8'h08;
    load_en = 1'b1;
    tick();
    model_start();
    fetch_req = 1'b0;
    at_neg();
    for (int i = 0; i < NI; i++) begin
      chk("collide_fetch_valid", i, fv[i], 0);
      chk("collide_busy", i, busy[i], 1);
      chk("collide_answered", i, sb[i].size(), 0);
    end
    load_en = 1'b0;
    tick();
    tick();
    tick();
    chk_done_delta("empty_load_done", 1);

    // Bytes outside loader mode leave memory untouched.
    load_byte_valid = 1'b1; load_byte = 8'hEE;
    tick();
    load_byte_valid = 1'b0;
    for (int i = 0; i < NI; i++) chk("stray_byte_busy", i, busy[i], 0);
    fetch_push(8'h00, 2, 32'h1413_1211, 1'b0);
    tick();
    fetch_push(8'h04, 0, 32'h0807_0605, 1'b0);
    tick();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
